bcd_counter_updown_ndigit: RTL

Parametrised N-digit decimal (BCD) counter. It counts up or down on a clock-enable tick, supports a synchronous parallel load, and can either wrap or saturate at its limits. It is the successor to the up-only N-digit BCD counter and is driven by the same tick-counter enable in the lab top levels. Overflow and underflow are reported as single-cycle pulses so that counters can be cascaded or events logged.

---
 rtl/bcd_counter_updown_ndigit.sv | 100 ++++++++++
 1 files changed

// File: rtl/bcd_counter_updown_ndigit.sv
// N-digit BCD up/down counter with parallel load and wrap/saturate limits.
// Carry and borrow ripple through all digits within one clock edge.
module bcd_counter_updown_ndigit #(
   parameter int Ndigit = 4,
   parameter bit WRAP   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*Ndigit-1:0]   load_value,
   output logic [4*Ndigit-1:0]   BCD,
   output logic                  ovf,
   output logic                  unf,
   output logic                  load_err,
   output logic                  zero
);

   localparam int W = 4 * Ndigit;

   logic [W-1:0]      bcd_reg, bcd_next;
   logic [W-1:0]      inc_value, dec_value;
   logic [Ndigit:0]   carry, borrow;
   logic [Ndigit-1:0] digit_valid;
   logic              all_nine, all_zero, load_ok;
   logic              ovf_reg, ovf_next;
   logic              unf_reg, unf_next;
   logic              load_err_reg, load_err_next;

   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   // Per-digit increment/decrement; a carry (borrow) survives a digit only at 9 (0).
   for (genvar gi = 0; gi < Ndigit; gi++) begin : g_digit
      logic [3:0] d;
      logic       is_nine, is_zero;

      assign d       = bcd_reg[4*gi +: 4];
      assign is_nine = (d == 4'd9);
      assign is_zero = (d == 4'd0);

      assign carry[gi+1]  = carry[gi]  & is_nine;
      assign borrow[gi+1] = borrow[gi] & is_zero;

      assign inc_value[4*gi +: 4] = !carry[gi]  ? d : (is_nine ? 4'd0 : d + 4'd1);
      assign dec_value[4*gi +: 4] = !borrow[gi] ? d : (is_zero ? 4'd9 : d - 4'd1);

      assign digit_valid[gi] = (load_value[4*gi +: 4] <= 4'd9);
   end

   // A carry out of the top digit means every digit was 9 (likewise borrow and 0).
   assign all_nine = carry[Ndigit];
   assign all_zero = borrow[Ndigit];
   assign load_ok  = &digit_valid;

   always_comb begin
      bcd_next      = bcd_reg;
      ovf_next      = 1'b0;
      unf_next      = 1'b0;
      load_err_next = 1'b0;
      if (load) begin
         if (load_ok)
            bcd_next = load_value;
         else
            load_err_next = 1'b1;
      end else if (en) begin
         if (up) begin
            ovf_next = all_nine;
            if (!all_nine || WRAP)
               bcd_next = inc_value;
         end else begin
            unf_next = all_zero;
            if (!all_zero || WRAP)
               bcd_next = dec_value;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_reg      <= '0;
         ovf_reg      <= 1'b0;
         unf_reg      <= 1'b0;
         load_err_reg <= 1'b0;
      end else begin
         bcd_reg      <= bcd_next;
         ovf_reg      <= ovf_next;
         unf_reg      <= unf_next;
         load_err_reg <= load_err_next;
      end
   end

   assign BCD      = bcd_reg;
   assign ovf      = ovf_reg;
   assign unf      = unf_reg;
   assign load_err = load_err_reg;
   assign zero     = (bcd_reg == '0);

endmodule
